// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: captures operands, adds CHUNK bits per clock with a
// registered carry, and returns sum, carry-out and signed overflow over valid/ready.
//   state | meaning
//   IDLE  | ready for operands, last result held on s_o/cout_o/ovf_o
//   ADD   | one chunk summed per cycle, carry kept in carry_q
//   DONE  | result valid, waiting for out_ready_i
module chunked_adder_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] s_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             busy_o
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   generate
      if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
         $error("chunked_adder_seq: WIDTH must be >= 2 and a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  w_q, w_d;
   logic [WIDTH-1:0]  s_q, s_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              out_valid_q, out_valid_d;

   logic [31:0]       base;
   logic [CHUNK-1:0]  a_chunk, b_chunk, sum_chunk;
   logic              carry_nxt;
   logic [WIDTH-1:0]  w_merged;

   // Chunk select and write-back use shifts so the index never needs a part-select.
   always_comb begin
      base      = 32'(idx_q) * 32'(CHUNK);
      a_chunk   = CHUNK'(a_q >> base);
      b_chunk   = CHUNK'(b_q >> base);
      {carry_nxt, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
      w_merged  = (w_q & ~(CHUNK_MASK << base)) | (WIDTH'(sum_chunk) << base);
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      w_d         = w_q;
      s_d         = s_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i ^ {WIDTH{sub_i}};
               carry_d = cin_i ^ sub_i;
               idx_d   = '0;
               w_d     = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            w_d     = w_merged;
            carry_d = carry_nxt;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               s_d         = w_merged;
               cout_d      = carry_nxt;
               // B already holds the inverted subtrahend, so one rule covers add and sub.
               ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_merged[WIDTH-1] != a_q[WIDTH-1]);
               out_valid_d = 1'b1;
               idx_d       = '0;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         w_q         <= '0;
         s_q         <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         w_q         <= w_d;
         s_q         <= s_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign out_valid_o = out_valid_q;
   assign s_o         = s_q;
   assign cout_o      = cout_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Scoreboard bench for chunked_adder_seq at CHUNK = 4, 16 and 1 (WIDTH = 16).
module tb_chunked_adder_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [15:0] a         [3];
   logic [15:0] b         [3];
   logic        cin       [3];
   logic        sub       [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [15:0] s         [3];
   logic        cout      [3];
   logic        ovf       [3];
   logic        busy      [3];

   int n_chk = 0;
   int n_err = 0;

   typedef struct packed {
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } res_t;

   res_t exp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      chunked_adder_seq #(
         .WIDTH(16),
         .CHUNK(g == 0 ? 4 : (g == 1 ? 16 : 1))
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid_i (in_valid[g]),
         .in_ready_o (in_ready[g]),
         .a_i        (a[g]),
         .b_i        (b[g]),
         .cin_i      (cin[g]),
         .sub_i      (sub[g]),
         .out_valid_o(out_valid[g]),
         .out_ready_i(out_ready[g]),
         .s_o        (s[g]),
         .cout_o     (cout[g]),
         .ovf_o      (ovf[g]),
         .busy_o     (busy[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Integer reference: unsigned result for s/cout, signed result for overflow.
   function automatic res_t model(input logic [15:0] av, input logic [15:0] bv,
                                  input logic c, input logic sb);
      res_t r;
      int   full, sr;
      if (!sb) begin
         full   = int'(av) + int'(bv) + int'(c);
         sr     = int'($signed(av)) + int'($signed(bv)) + int'(c);
         r.cout = (full > 65535);
      end else begin
         full   = int'(av) - int'(bv) - int'(c);
         sr     = int'($signed(av)) - int'($signed(bv)) - int'(c);
         r.cout = (full >= 0);
      end
      r.s   = full[15:0];
      r.ovf = (sr > 32767) || (sr < -32768);
      return r;
   endfunction

   task automatic start_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                           input logic c, input logic sb);
      int guard = 0;
      while (!in_ready[k] && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("in_ready_before_op", 32'(in_ready[k]), 1);
      exp_q.push_back(model(av, bv, c, sb));
      a[k] = av; b[k] = bv; cin[k] = c; sub[k] = sb; in_valid[k] = 1'b1;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      a[k]   = 16'($urandom);
      b[k]   = 16'($urandom);
      cin[k] = 1'($urandom);
      sub[k] = 1'($urandom);
   endtask

   task automatic wait_result(input int k, input int exp_lat, input string tag);
      int   lat = 0;
      res_t e;
      while (!out_valid[k] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_valid"}, 32'(out_valid[k]), 1);
      if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_s"},    32'(s[k]),    32'(e.s));
         check({tag, "_cout"}, 32'(cout[k]), 32'(e.cout));
         check({tag, "_ovf"},  32'(ovf[k]),  32'(e.ovf));
      end
      check({tag, "_busy"}, 32'(busy[k]), 1);
   endtask

   task automatic accept(input int k, input int delay, input string tag);
      repeat (delay) begin @(posedge clk); #1; end
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
      check({tag, "_valid_dropped"}, 32'(out_valid[k]), 0);
      check({tag, "_idle_ready"},    32'(in_ready[k]),  1);
   endtask

   logic [15:0] ta [7] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234, 16'h0000};
   logic [15:0] tb [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h4321, 16'h0000};
   logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  seen;
      int  lat_of [3] = '{4, 1, 16};
      int  nrand  [3] = '{1000, 150, 60};
      res_t r;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         a[k] = '0; b[k] = '0; cin[k] = 1'b0; sub[k] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid[0]), 0);
      check("rst_s",         32'(s[0]),         0);
      check("rst_cout",      32'(cout[0]),      0);
      check("rst_ovf",       32'(ovf[0]),       0);
      check("rst_busy",      32'(busy[0]),      0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(in_ready[0]), 1);

      // spot-check the model against hand-derived values from the datasheet cases
      r = model(16'h8000, 16'h0001, 1'b0, 1'b1);
      check("model_sub_ovf", 32'({r.s, r.cout, r.ovf}), 32'({16'h7FFF, 1'b1, 1'b1}));

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 7; i++) begin
            start_op(k, ta[i], tb[i], tc[i], ts[i]);
            wait_result(k, lat_of[k], $sformatf("dir%0d_%0d", k, i));
            accept(k, 0, $sformatf("dir%0d_%0d", k, i));
         end
      end

      // backpressure: result held while out_ready low, input not taken in DONE
      start_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
      wait_result(0, 4, "bp");
      in_valid[0] = 1'b1;
      a[0] = 16'hAAAA;
      b[0] = 16'h5555;
      repeat (10) begin
         @(posedge clk); #1;
         check("bp_hold_valid", 32'(out_valid[0]), 1);
         check("bp_hold_s",     32'(s[0]),         32'h2345);
         check("bp_in_ready",   32'(in_ready[0]),  0);
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 32'(out_valid[0]), 0);
      check("bp_release_ready", 32'(in_ready[0]),  1);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("bp_no_extra_op", 32'(busy[0]), 0);

      // reset two cycles into ADD: operation dropped, outputs cleared
      start_op(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_in_add", 32'(busy[0]), 1);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid[0]), 0);
      check("abort_s",         32'(s[0]),         0);
      check("abort_busy",      32'(busy[0]),      0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid[0]) seen++;
      end
      check("abort_no_result",   seen, 0);
      check("abort_in_ready",    32'(in_ready[0]), 1);
      check("abort_s_after",     32'(s[0]),        0);

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < nrand[k]; i++) begin
            start_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            wait_result(k, lat_of[k], $sformatf("rnd%0d", k));
            accept(k, $urandom_range(0, 2), $sformatf("rnd%0d", k));
         end
      end

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
